// File: rtl/arm_pipe_pkg.sv
// Shared constants for the ARM pipeline hazard/forwarding logic:
// forwarding-select encodings, the never-forwarded PC index and the
// hazard FSM state encodings.
package arm_pipe_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int PC_REG    = 15;

  // Operand source selects driven to the EX operand muxes
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // Hazard FSM states
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/hazard_forwarding_unit_if.sv
// Bundle between the decode/control side and the hazard forwarding unit.
// master: control side that presents the ID instruction and branch result.
// slave : the hazard forwarding unit itself.
interface hazard_forwarding_unit_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_rf_enable;
  logic             id_load_inst;
  logic             ex_br_taken;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             pc_ld;
  logic             ifid_ld;
  logic             ifid_flush;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_rf_enable, id_load_inst, ex_br_taken,
    input  fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, ifid_flush, ex_bubble,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_rf_enable, id_load_inst, ex_br_taken,
    output fwd_a_sel, fwd_b_sel, pc_ld, ifid_ld, ifid_flush, ex_bubble,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_dest_pipe.sv
// Three-entry destination tracker (EX/MEM/WB). Each entry is packed as
// {rd, rf_en, load, valid}; a bubble or NOP enters the EX slot invalid.
module hazard_dest_pipe #(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rf_enable,
  input  logic             id_load_inst,
  input  logic             id_valid,
  input  logic             ex_bubble,
  output logic [REG_W+2:0] ex_entry_r,
  output logic [REG_W+2:0] mem_entry_r,
  output logic [REG_W+2:0] wb_entry_r
);

  logic [REG_W+2:0] id_entry_s;

  // Pack the ID destination; bubbled or NOP instructions enter as invalid
  always_comb begin
    id_entry_s = {id_rd, id_rf_enable, id_load_inst, (id_valid & ~ex_bubble)};
  end

  // Advance destination entries one stage per pipeline edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_entry_r  <= {(REG_W+3){1'b0}};
      mem_entry_r <= {(REG_W+3){1'b0}};
      wb_entry_r  <= {(REG_W+3){1'b0}};
    end else begin
      ex_entry_r  <= id_entry_s;
      mem_entry_r <= ex_entry_r;
      wb_entry_r  <= mem_entry_r;
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// Hazard and forwarding unit for the 5-stage ARM pipeline. Selects operand
// forwarding sources, inserts a one-cycle load-use stall and flushes IF/ID
// and EX on a taken branch.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall/flush counters;
// when undefined the counter outputs are tied to zero).
module hazard_forwarding_unit #(
  parameter int REG_W  = arm_pipe_pkg::REG_W_DEF,
  parameter int PC_REG = arm_pipe_pkg::PC_REG,
  parameter int CNT_W  = arm_pipe_pkg::CNT_W_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  hazard_forwarding_unit_if.slave  bus
);
  import arm_pipe_pkg::*;

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic [REG_W+2:0] ex_entry_s;
  logic [REG_W+2:0] mem_entry_s;
  logic [REG_W+2:0] wb_entry_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;
  logic             hazard_s;
  logic             pc_ld_s;
  logic             ifid_ld_s;
  logic             ifid_flush_s;
  logic             ex_bubble_s;
  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;

  // A source matches an in-flight entry that writes the same register; PC is never forwarded
  function automatic logic src_match(input logic use_src, input logic [REG_W-1:0] src,
                                     input logic [REG_W+2:0] ent);
    src_match = use_src && ent[0] && ent[2] && (ent[REG_W+2:3] == src) && (src != PC_IDX);
  endfunction

  // Youngest producer wins; a load in EX has no result yet so it is skipped
  function automatic logic [1:0] fwd_pick(input logic use_src, input logic [REG_W-1:0] src,
                                          input logic [REG_W+2:0] ex_e,
                                          input logic [REG_W+2:0] mem_e,
                                          input logic [REG_W+2:0] wb_e);
    if (src_match(use_src, src, ex_e) && !ex_e[1]) begin
      fwd_pick = FWD_EX;
    end else if (src_match(use_src, src, mem_e)) begin
      fwd_pick = FWD_MEM;
    end else if (src_match(use_src, src, wb_e)) begin
      fwd_pick = FWD_WB;
    end else begin
      fwd_pick = FWD_RF;
    end
  endfunction

  hazard_dest_pipe #(.REG_W(REG_W)) u_dest_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rd        (bus.id_rd),
    .id_rf_enable (bus.id_rf_enable),
    .id_load_inst (bus.id_load_inst),
    .id_valid     (bus.id_valid),
    .ex_bubble    (ex_bubble_s),
    .ex_entry_r   (ex_entry_s),
    .mem_entry_r  (mem_entry_s),
    .wb_entry_r   (wb_entry_s)
  );

  // Operand forwarding selects and load-use detection for the ID instruction
  always_comb begin
    fwd_a_s  = FWD_RF;
    fwd_b_s  = FWD_RF;
    hazard_s = 1'b0;
    if (bus.id_valid) begin
      fwd_a_s  = fwd_pick(bus.id_use_rn, bus.id_rn, ex_entry_s, mem_entry_s, wb_entry_s);
      fwd_b_s  = fwd_pick(bus.id_use_rm, bus.id_rm, ex_entry_s, mem_entry_s, wb_entry_s);
      hazard_s = ex_entry_s[1] && (src_match(bus.id_use_rn, bus.id_rn, ex_entry_s) ||
                                   src_match(bus.id_use_rm, bus.id_rm, ex_entry_s));
    end else begin
      fwd_a_s  = FWD_RF;
      fwd_b_s  = FWD_RF;
      hazard_s = 1'b0;
    end
  end

  // Pipeline enables and next state; a taken branch overrides any stall
  always_comb begin
    pc_ld_s      = 1'b1;
    ifid_ld_s    = 1'b1;
    ifid_flush_s = 1'b0;
    ex_bubble_s  = 1'b0;
    state_nxt_s  = ST_RUN;
    if (bus.ex_br_taken) begin
      ifid_flush_s = 1'b1;
      ex_bubble_s  = 1'b1;
      state_nxt_s  = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hazard_s) begin
            pc_ld_s     = 1'b0;
            ifid_ld_s   = 1'b0;
            ex_bubble_s = 1'b1;
            state_nxt_s = ST_STALL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_STALL: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Hazard FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign bus.fwd_a_sel  = fwd_a_s;
  assign bus.fwd_b_sel  = fwd_b_s;
  assign bus.pc_ld      = pc_ld_s;
  assign bus.ifid_ld    = ifid_ld_s;
  assign bus.ifid_flush = ifid_flush_s;
  assign bus.ex_bubble  = ex_bubble_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             stall_inc_s;

  assign stall_inc_s = (state_r == ST_RUN) && (state_nxt_s == ST_STALL);

  // Saturating counts of stall entries and taken-branch flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bus.ex_br_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
